// File: rtl/stencil_1d_taps.sv
// Streaming 1-D FIR stencil: reads len samples, slides a TAPS-wide window,
// writes one wrap-around weighted sum per full window.
module stencil_1d_taps #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int TAPS   = 3,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tstart,
  input  logic [LEN_W-1:0]       len,
  input  logic [TAPS*DATA_W-1:0] coef,
  output logic [ADDR_W-1:0]      in_addr,
  output logic                   in_rd_en,
  input  logic [DATA_W-1:0]      in_rd_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_wr_en,
  output logic [DATA_W-1:0]      out_wr_data,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [LEN_W-1:0] TAPS_L  = LEN_W'(TAPS);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  state_t                  state, state_nxt;
  logic                    drain_cnt;
  logic                    finish;
  logic [LEN_W-1:0]        len_eff;
  logic [LEN_W-1:0]        len_q;
  logic [TAPS*DATA_W-1:0]  coef_q;
  logic                    accept, reject, last_rd;
  logic                    rd_valid;
  logic [LEN_W-1:0]        rcv_cnt;
  logic [DATA_W-1:0]       win     [TAPS];
  logic [DATA_W-1:0]       win_nxt [TAPS];
  logic [DATA_W-1:0]       acc;

  // Lengths beyond the memory depth are clamped so the read address never wraps.
  assign len_eff = (len > DEPTH_L) ? DEPTH_L : len;
  assign accept  = (state == IDLE) && tstart && (len_eff >= TAPS_L);
  assign reject  = (state == IDLE) && tstart && (len_eff <  TAPS_L);
  assign last_rd = (state == RUN) && (LEN_W'(in_addr) == len_q - LEN_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // NOTE: combinational blocks assign a default to every output first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_rd)   state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // DRAIN lasts two cycles: one for the last read return, one for its write.
  always_comb begin
    busy   = 1'b0;
    finish = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DRAIN: begin
        busy   = 1'b1;
        finish = drain_cnt;
      end
      default: ;
    endcase
  end

  // NOTE: run parameters are data-only registers; they are always written at
  // start before being read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      len_q  <= len_eff;
      coef_q <= coef;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
    end else begin
      done <= reject || finish;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rd_en <= 1'b0;
      in_addr  <= '0;
    end else if (accept) begin
      in_rd_en <= 1'b1;
      in_addr  <= '0;
    end else if (state == RUN) begin
      if (last_rd) in_rd_en <= 1'b0;
      else         in_addr  <= in_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid <= 1'b0;
    else        rd_valid <= in_rd_en;
  end

  // The MAC sees the window as it will be after the returning sample shifts
  // in, so the registered result lands together with the shift.
  always_comb begin
    for (int k = 0; k < TAPS - 1; k++) win_nxt[k] = win[k + 1];
    win_nxt[TAPS-1] = in_rd_data;
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      // Low DATA_W bits of the signed product; the sum wraps by design.
      acc = acc + DATA_W'($signed(coef_q[k*DATA_W +: DATA_W]) * $signed(win_nxt[k]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) win[k] <= '0;
      rcv_cnt     <= '0;
      out_wr_en   <= 1'b0;
      out_addr    <= '0;
      out_wr_data <= '0;
    end else begin
      out_wr_en <= 1'b0;
      if (accept) begin
        for (int k = 0; k < TAPS; k++) win[k] <= '0;
        rcv_cnt <= '0;
      end else if (rd_valid) begin
        for (int k = 0; k < TAPS; k++) win[k] <= win_nxt[k];
        rcv_cnt <= rcv_cnt + LEN_W'(1);
        if (rcv_cnt >= TAPS_L - LEN_W'(1)) begin
          out_wr_en   <= 1'b1;
          out_addr    <= ADDR_W'(rcv_cnt - (TAPS_L - LEN_W'(1)));
          out_wr_data <= acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_stencil_1d_taps.sv
// Self-checking bench for stencil_1d_taps: directed corner cases plus random
// runs compared against a plain-arithmetic FIR model.
module tb_stencil_1d_taps;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int TAPS   = 3;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   tstart = 1'b0;
  logic [LEN_W-1:0]       len = '0;
  logic [TAPS*DATA_W-1:0] coef = '0;
  logic [ADDR_W-1:0]      in_addr;
  logic                   in_rd_en;
  logic [DATA_W-1:0]      in_rd_data;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_wr_en;
  logic [DATA_W-1:0]      out_wr_data;
  logic                   busy;
  logic                   done;

  stencil_1d_taps #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .TAPS(TAPS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tstart(tstart), .len(len), .coef(coef),
    .in_addr(in_addr), .in_rd_en(in_rd_en), .in_rd_data(in_rd_data),
    .out_addr(out_addr), .out_wr_en(out_wr_en), .out_wr_data(out_wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] in_mem [DEPTH];
  always @(posedge clk) if (in_rd_en) in_rd_data <= in_mem[in_addr];

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
  } ev_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  busy_cnt, busy_first, done_cnt, done_cyc;

  always @(negedge clk) begin
    if (in_rd_en)  rd_q.push_back('{cyc, int'(in_addr), 32'd0});
    if (out_wr_en) wr_q.push_back('{cyc, int'(out_addr), out_wr_data});
    if (busy) begin
      if (busy_cnt == 0) busy_first = cyc;
      busy_cnt++;
    end
    if (done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int cur_c [TAPS];
  int cur_len;
  int t0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    busy_cnt = 0; busy_first = 0; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int model_out(input int j);
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += cur_c[k] * int'(in_mem[j + k]);
    return s;
  endfunction

  task automatic start_run();
    clear_mon();
    for (int k = 0; k < TAPS; k++) coef[k*DATA_W +: DATA_W] = cur_c[k];
    len    = LEN_W'(cur_len);
    tstart = 1'b1;
    t0     = cyc;
    @(posedge clk);
    #1 tstart = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < cur_len + 20 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1;
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_run();
    bit short_run = (cur_len < TAPS);
    int n_rd = short_run ? 0 : cur_len;
    int n_wr = short_run ? 0 : cur_len - TAPS + 1;
    check("rd_count", rd_q.size(), n_rd);
    for (int k = 0; k < n_rd && k < rd_q.size(); k++) begin
      check("rd_cyc",  rd_q[k].cyc,  t0 + 1 + k);
      check("rd_addr", rd_q[k].addr, k);
    end
    check("wr_count", wr_q.size(), n_wr);
    for (int j = 0; j < n_wr && j < wr_q.size(); j++) begin
      check("wr_cyc",  wr_q[j].cyc,  t0 + TAPS + 2 + j);
      check("wr_addr", wr_q[j].addr, j);
      check("wr_data", wr_q[j].data, model_out(j));
    end
    check("busy_cnt", busy_cnt, short_run ? 0 : cur_len + 2);
    if (!short_run) check("busy_first", busy_first, t0 + 1);
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_cyc, short_run ? t0 + 1 : t0 + cur_len + 3);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_addr"},     32'(in_addr),     32'd0);
    check({tag, "_in_rd_en"},    32'(in_rd_en),    32'd0);
    check({tag, "_out_addr"},    32'(out_addr),    32'd0);
    check({tag, "_out_wr_en"},   32'(out_wr_en),   32'd0);
    check({tag, "_out_wr_data"}, out_wr_data,      32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
  endtask

  task automatic full_run(input int l);
    cur_len = l;
    start_run();
    wait_done();
    idle(3);
    check_run();
  endtask

  initial begin
    int plan_out [6];
    plan_out = '{8, 12, 16, 20, 24, 28};

    idle(2);
    check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Reference case: ramp data, {1,2,1} coefficients, len == DEPTH.
    for (int i = 0; i < DEPTH; i++) in_mem[i] = 32'(i + 1);
    cur_c = '{1, 2, 1};
    full_run(8);
    for (int j = 0; j < 6 && j < wr_q.size(); j++)
      check("plan_data", wr_q[j].data, plan_out[j]);

    full_run(3);
    if (wr_q.size() > 0) check("len3_data", wr_q[0].data, 32'd8);
    full_run(2);
    full_run(0);

    for (int i = 0; i < DEPTH; i++) in_mem[i] = 32'h7FFF_FFFF;
    cur_c = '{2, 0, 0};
    full_run(8);
    foreach (wr_q[j]) check("wrap_pos", wr_q[j].data, 32'hFFFF_FFFE);

    for (int i = 0; i < DEPTH; i++) in_mem[i] = 32'd5;
    cur_c = '{-1, 0, 0};
    full_run(6);
    foreach (wr_q[j]) check("neg_coef", wr_q[j].data, 32'hFFFF_FFFB);

    // Start and coefficient/length changes while busy must be ignored;
    // a back-to-back start right at done begins a fresh run.
    for (int i = 0; i < DEPTH; i++) in_mem[i] = $urandom;
    for (int k = 0; k < TAPS; k++) cur_c[k] = int'($urandom_range(0, 255)) - 128;
    cur_len = 8;
    start_run();
    for (int i = 0; i < 20 && cyc != t0 + 3; i++) @(negedge clk);
    #1;
    tstart = 1'b1;
    coef   = {$urandom, $urandom, $urandom};
    len    = LEN_W'($urandom_range(0, DEPTH));
    @(posedge clk);
    #1 tstart = 1'b0;
    wait_done();
    check_run();
    for (int i = 0; i < DEPTH; i++) in_mem[i] = $urandom;
    for (int k = 0; k < TAPS; k++) cur_c[k] = int'($urandom);
    cur_len = 7;
    start_run();
    wait_done();
    idle(3);
    check_run();

    // Asynchronous reset in the middle of a run.
    for (int i = 0; i < DEPTH; i++) in_mem[i] = 32'(i + 1);
    cur_c = '{1, 2, 1};
    cur_len = 8;
    start_run();
    for (int i = 0; i < 20 && cyc != t0 + 6; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    clear_mon();
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    check("abort_rd",   rd_q.size(), 0);
    check("abort_wr",   wr_q.size(), 0);
    check("abort_done", done_cnt,    0);
    full_run(8);
    for (int j = 0; j < 6 && j < wr_q.size(); j++)
      check("rerun_data", wr_q[j].data, plan_out[j]);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) in_mem[i] = $urandom;
      for (int k = 0; k < TAPS; k++) cur_c[k] = int'($urandom);
      full_run($urandom_range(0, DEPTH));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/stencil_1d_taps.md
# stencil_1d_taps

Parametrised 1-D FIR stencil engine, the generalised successor to the fixed two-tap `stencil_1d` kernel. On a start pulse it streams `len` words from an external read-port memory and slides a TAPS-wide window over them. For every full window it writes one signed weighted sum to an external write-port memory. It sits between two memref-style SRAM ports in the HIR-generated datapath and replaces the hard-coded `weighted_sum` call with a runtime-loaded coefficient vector.

## Interface
- DATA_W, 32: sample, coefficient and result width (two's complement)
- DEPTH, 64: maximum stream length; memory depth
- TAPS, 3: window width, legal range 2..8
- ADDR_W, $clog2(DEPTH): address width
- LEN_W, $clog2(DEPTH+1): width of `len`

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tstart  in  1  start request, sampled only while idle
- len  in  LEN_W  number of input samples, latched at start
- coef  in  TAPS*DATA_W  coefficients; coef[k] occupies bits [k*DATA_W +: DATA_W] and weights in[i+k]; latched at start
- in_addr  out  ADDR_W  read address
- in_rd_en  out  1  read strobe
- in_rd_data  in  DATA_W  read data, valid exactly 1 cycle after `in_rd_en`
- out_addr  out  ADDR_W  write address
- out_wr_en  out  1  write strobe
- out_wr_data  out  DATA_W  write data
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse

## Operation
- The FSM has three states: IDLE, RUN and DRAIN.
  - IDLE, tstart=1 and len>=TAPS: latch `len` and `coef`, then go to RUN.
  - IDLE, tstart=1 and len<TAPS: no reads, no writes; pulse `done` next cycle; stay in IDLE.
- RUN issues one read per cycle at addresses 0..len-1, with no gaps. After the last read it moves to DRAIN.
- DRAIN flushes the read-return stage and the MAC stage, pulses `done`, and returns to IDLE.
- Returned data shifts into a TAPS-deep window register.
  - The window is valid once TAPS samples have arrived since start.
  - The window is cleared at start, so no stale data is reused across runs.
- MAC computes sum over k of coef[k]*win[k], where win[0] is the oldest sample.
  - Products are signed DATA_W x DATA_W.
  - The result is the sum truncated to its low DATA_W bits, i.e. wrap-around with no saturation.
  - The result is registered once before the write.
- Output index j (0..len-TAPS) is written to out_addr=j. A run produces exactly len-TAPS+1 writes.
- `tstart` asserted while busy is ignored; there is no queueing.
- A change to `coef` or `len` during a run has no effect.
- Reset mid-run aborts immediately:
  - All outputs return to reset values.
  - No further reads or writes occur.
  - No `done` pulse is issued.
- Reset values: in_addr=0, in_rd_en=0, out_addr=0, out_wr_en=0, out_wr_data=0, busy=0, done=0. State is IDLE and the window is zeroed.
- `in_addr` and `out_addr` hold their last value when the strobe is low. `out_wr_data` is don't-care when `out_wr_en`=0 except after reset.

## Timing
Let T be the cycle in which `tstart` is sampled high in IDLE with len>=TAPS.

- Read k (k=0..len-1): `in_rd_en`=1 with `in_addr`=k in cycle T+1+k.
- in_rd_data[k] is captured in cycle T+2+k.
- Write j: `out_wr_en`=1, `out_addr`=j in cycle T+TAPS+2+j. Writes are back-to-back with no bubbles.
- Last write occurs in cycle T+len+2.
- `busy`=1 from cycle T+1 through T+len+2 inclusive.
- `done`=1 in cycle T+len+3 only, with busy=0 in that cycle.
- A new `tstart` is accepted in cycle T+len+3 or later.
- len<TAPS: `done`=1 in cycle T+1; `busy` never asserts.
- len=DEPTH: the final read address is DEPTH-1 and must not wrap.

## Test plan
- TAPS=3, DEPTH=8, len=8, in[k]=k+1, coef={1,2,1}:
  - out[0..5] must be 8,12,16,20,24,28, written in cycles T+5..T+10.
  - `done` pulses at T+11.
- Boundary length, len=3 (=TAPS), same data: a single write out[0]=8 at T+5; `done` at T+6.
- len=2 (<TAPS): no `in_rd_en`, no `out_wr_en`; `done` at T+1; `busy` stays 0.
- Arithmetic:
  - in[*]=0x7FFFFFFF, coef={2,0,0}: every output must be 0xFFFFFFFE (wrap).
  - in[*]=5, coef={-1,0,0}: every output must be 0xFFFFFFFB.
- Reassert `tstart` and change `coef` at T+3 during a run: outputs are unchanged from the original-coefficient results and there is no second run. A second `tstart` at T+len+3 starts a fresh run with clean window results.
- Deassert `rst_n` asynchronously at T+6 of a len=8 run:
  - All outputs go to 0 immediately, with no `done`.
  - After release, a new start reproduces the full expected output set.
